// File: rtl/imm_extend_unit.sv
// imm_extend_unit
// Handshaked immediate extender between decode and the execute operand mux.
// Modes: 00 zext8, 01 zext12, 10 sign-extended shifted branch offset,
// 11 rotated immediate (imm8 ROR 2*rot4) produced by a serial rotator.
// A one-entry output buffer (HOLD) gives one result per cycle for the
// non-rotating modes when the consumer keeps out_ready high.
module imm_extend_unit #(
    parameter int WIDTH    = 32,
    parameter int ROT_STEP = 2,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      instr,
    input  logic [1:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ext_imm,
    output logic             rot_carry,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t          state;
    logic [CW-1:0]   remain;

    logic            accept;
    logic [WIDTH-1:0] zext8;
    logic [WIDTH-1:0] zext12;
    logic [WIDTH-1:0] br_sext;
    logic [WIDTH-1:0] br_imm;
    logic [CW-1:0]   rot_amt;
    logic [CW-1:0]   step;
    logic [WIDTH-1:0] rot_next;

    // A new op may enter when empty, or when the held result leaves this cycle.
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // Immediate candidates decoded straight from the incoming instruction.
    assign zext8   = {{(WIDTH-8){1'b0}}, instr[7:0]};
    assign zext12  = {{(WIDTH-12){1'b0}}, instr[11:0]};
    assign br_sext = {{(WIDTH-24){instr[23]}}, instr};
    assign br_imm  = br_sext << BR_SHIFT;
    assign rot_amt = CW'({instr[11:8], 1'b0});

    // Per-cycle rotate amount: a full step, or whatever is left.
    assign step = (remain < CW'(ROT_STEP)) ? remain : CW'(ROT_STEP);

    // Small rotator: only even amounts up to ROT_STEP ever occur, so mux
    // between those fixed rotations instead of building a full barrel.
    always_comb begin
        rot_next = ext_imm;
        for (int k = 1; k <= ROT_STEP/2; k++) begin
            if (step == CW'(2*k))
                rot_next = (ext_imm >> (2*k)) | (ext_imm << (WIDTH - 2*k));
        end
    end

    // Control FSM; ext_imm doubles as the rotation working register, so it
    // only changes on accept or while rotating and is frozen in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            ext_imm   <= '0;
            rot_carry <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        rot_carry <= 1'b0;
                        case (imm_src)
                            2'b00: begin
                                ext_imm   <= zext8;
                                remain    <= '0;
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end
                            2'b01: begin
                                ext_imm   <= zext12;
                                remain    <= '0;
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end
                            2'b10: begin
                                ext_imm   <= br_imm;
                                remain    <= '0;
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end
                            default: begin
                                ext_imm <= zext8;
                                remain  <= rot_amt;
                                if (rot_amt == '0) begin
                                    state     <= HOLD;
                                    out_valid <= 1'b1;
                                    busy      <= 1'b0;
                                end else begin
                                    state     <= ROT;
                                    out_valid <= 1'b0;
                                    busy      <= 1'b1;
                                end
                            end
                        endcase
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ROT: begin
                    ext_imm <= rot_next;
                    remain  <= remain - step;
                    if (remain == step) begin
                        // Carry follows the final rotated MSB.
                        rot_carry <= rot_next[WIDTH-1];
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
